// File: rtl/leve_tb_pkg.sv
// Shared HTIF constants, monitor state enums and the tohost command decoder
// for the LEVE simulation host monitor.
package leve_tb_pkg;

  localparam logic [7:0]  HTIF_DEV_CON  = 8'd1;
  localparam logic [7:0]  HTIF_CMD_PUTC = 8'd1;
  localparam logic [31:0] HTIF_ACK      = 32'h1;

  typedef enum logic {CH_RUN, CH_EXITED} tb_ch_state_t;
  typedef enum logic [1:0] {MON_RUN, MON_DONE, MON_TMO} tb_mon_state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_EXIT, CMD_PUTC} htif_cmd_t;

  // PUTC is matched before EXIT: a console byte may itself be odd.
  function automatic htif_cmd_t htif_decode(input logic [7:0] dev,
                                            input logic [7:0] cmd,
                                            input logic       lsb);
    htif_cmd_t res;
    if (dev == HTIF_DEV_CON && cmd == HTIF_CMD_PUTC) res = CMD_PUTC;
    else if (lsb)                                    res = CMD_EXIT;
    else                                             res = CMD_NONE;
    return res;
  endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// Single-clock FIFO holding console bytes; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module tb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: non-blocking assignments in clocked blocks keep every register
  // sampling pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers already
  // makes stale contents unreachable, and it keeps the array a plain RAM.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tb_host_monitor.sv
// Multi-hart HTIF host monitor: exit/putc decode, console FIFO, watchdog and
// aggregate verdict. Define LEVE_TB_FINISH_EN to print the verdict and $finish.
module tb_host_monitor
  import leve_tb_pkg::*;
#(
  parameter int NCH       = 1,
  parameter int TIMEOUT   = 1_000_000,
  parameter int CON_DEPTH = 16
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic [NCH-1:0]            tohost_we,
  input  logic [NCH*32-1:0]         tohost,
  output logic [NCH-1:0]            tohost_ready,
  output logic [NCH-1:0]            fromhost_we,
  output logic [31:0]               fromhost,
  output logic                      con_valid,
  output logic [7:0]                con_data,
  input  logic                      con_ready,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [31:0]               exit_code,
  output logic [$clog2(NCH):0]      exit_ch
);

  localparam int          CHW     = $clog2(NCH) + 1;
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT - 1) : 32'd0;

  logic [31:0]   ch_val   [NCH];
  htif_cmd_t     ch_cmd   [NCH];
  tb_ch_state_t  ch_state [NCH];
  tb_ch_state_t  ch_next  [NCH];
  tb_mon_state_t mon_state, mon_next;

  logic [NCH-1:0] putc_req, grant, accept, exit_now;
  logic           taken, mon_run, wd_expire, all_exited;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     push_data, fifo_rdata;
  logic           exit_hit;
  logic [31:0]    exit_val, wd_cnt;
  logic [CHW-1:0] exit_idx;

  assign mon_run   = (mon_state == MON_RUN);
  assign wd_expire = WD_EN && mon_run && (wd_cnt == WD_LAST);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    taken     = 1'b0;
    putc_req  = '0;
    grant     = '0;
    accept    = '0;
    exit_now  = '0;
    push_data = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_val[i] = tohost[i*32 +: 32];
      ch_cmd[i] = htif_decode(ch_val[i][31:24], ch_val[i][23:16], ch_val[i][0]);
      putc_req[i] = mon_run && (ch_state[i] == CH_RUN) && tohost_we[i]
                    && (ch_cmd[i] == CMD_PUTC);
      if (putc_req[i] && !taken) begin
        grant[i]  = 1'b1;
        taken     = 1'b1;
        push_data = ch_val[i][7:0];
      end
    end
    for (int i = 0; i < NCH; i++) begin
      tohost_ready[i] = !(putc_req[i] && (!grant[i] || fifo_full));
      accept[i]   = mon_run && (ch_state[i] == CH_RUN) && tohost_we[i] && tohost_ready[i];
      exit_now[i] = accept[i] && (ch_cmd[i] == CMD_EXIT);
    end
  end

  assign fifo_push = |(grant & accept);
  assign fifo_pop  = con_valid && con_ready;

  tb_sync_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .push  (fifo_push),
    .wdata (push_data),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_rdata;

  always_comb begin
    all_exited = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      ch_next[i] = ch_state[i];
      if (exit_now[i]) ch_next[i] = CH_EXITED;
      if (ch_next[i] != CH_EXITED) all_exited = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NCH; i++) ch_state[i] <= CH_RUN;
    end else begin
      for (int i = 0; i < NCH; i++) ch_state[i] <= ch_next[i];
    end
  end

  // Watchdog expiry outranks a completing EXIT in the same cycle.
  always_comb begin
    mon_next = mon_state;
    if (mon_run) begin
      if (wd_expire)       mon_next = MON_TMO;
      else if (all_exited) mon_next = MON_DONE;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) mon_state <= MON_RUN;
    else       mon_state <= mon_next;
  end

  // Scan high-to-low so the lowest channel index wins a same-cycle tie.
  always_comb begin
    exit_hit = 1'b0;
    exit_val = '0;
    exit_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (exit_now[i] && (ch_val[i][31:1] != '0)) begin
        exit_hit = 1'b1;
        exit_val = ch_val[i];
        exit_idx = CHW'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      exit_code   <= '0;
      exit_ch     <= '0;
      fromhost_we <= '0;
      wd_cnt      <= '0;
    end else begin
      if (mon_run && exit_hit && (exit_code == '0)) begin
        exit_code <= exit_val;
        exit_ch   <= exit_idx;
      end
      fromhost_we <= accept & ~exit_now;
      if (mon_run) wd_cnt <= wd_cnt + 32'd1;
    end
  end

  assign fromhost = HTIF_ACK;
  assign done     = (mon_state != MON_RUN);
  assign timeout  = (mon_state == MON_TMO);
  assign pass     = done && !timeout && (exit_code == '0);

`ifdef LEVE_TB_FINISH_EN
  logic done_q, finish_pend;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      done_q      <= 1'b0;
      finish_pend <= 1'b0;
    end else begin
      done_q <= done;
      if (done && !done_q) finish_pend <= 1'b1;
    end
  end

  always @(posedge CLK) begin
    if (RSTn) begin
      if (fifo_pop) $write("%c", con_data);
      if (done && !done_q) begin
        if (timeout)   $display("[TESTBENCH] [TIMEOUT]");
        else if (pass) $display("[TESTBENCH] [PASS]");
        else $display("[TESTBENCH] [FAIL] exit code %08H, test number %2d",
                      exit_code, exit_code >> 1);
      end
      if (finish_pend && fifo_empty) $finish;
    end
  end
`endif

endmodule

// File: tb/tb_tb_host_monitor.sv
// Directed bench for tb_host_monitor: three instances cover single-hart exit,
// two-hart console arbitration with a shallow FIFO, and the watchdog.
module tb_tb_host_monitor;

  logic CLK;
  logic RSTn;
  int   n_chk;
  int   n_fail;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance a: NCH=1, default watchdog, depth 16
  logic        a_we, a_ready, a_fwe, a_cv, a_cr, a_done, a_pass, a_tmo;
  logic [31:0] a_tohost, a_fh, a_ec;
  logic [7:0]  a_cd;
  logic [0:0]  a_ech;
  // Instance b: NCH=2, watchdog off, depth 4
  logic [1:0]  b_we, b_ready, b_fwe, b_ech;
  logic [63:0] b_tohost;
  logic [31:0] b_fh, b_ec;
  logic        b_cv, b_cr, b_done, b_pass, b_tmo;
  logic [7:0]  b_cd;
  // Instance c: NCH=1, TIMEOUT=100
  logic        c_we, c_ready, c_fwe, c_cv, c_cr, c_done, c_pass, c_tmo;
  logic [31:0] c_tohost, c_fh, c_ec;
  logic [7:0]  c_cd;
  logic [0:0]  c_ech;

  tb_host_monitor #(.NCH(1)) u_a (
    .CLK(CLK), .RSTn(RSTn), .tohost_we(a_we), .tohost(a_tohost),
    .tohost_ready(a_ready), .fromhost_we(a_fwe), .fromhost(a_fh),
    .con_valid(a_cv), .con_data(a_cd), .con_ready(a_cr), .done(a_done),
    .pass(a_pass), .timeout(a_tmo), .exit_code(a_ec), .exit_ch(a_ech)
  );

  tb_host_monitor #(.NCH(2), .TIMEOUT(0), .CON_DEPTH(4)) u_b (
    .CLK(CLK), .RSTn(RSTn), .tohost_we(b_we), .tohost(b_tohost),
    .tohost_ready(b_ready), .fromhost_we(b_fwe), .fromhost(b_fh),
    .con_valid(b_cv), .con_data(b_cd), .con_ready(b_cr), .done(b_done),
    .pass(b_pass), .timeout(b_tmo), .exit_code(b_ec), .exit_ch(b_ech)
  );

  tb_host_monitor #(.NCH(1), .TIMEOUT(100), .CON_DEPTH(2)) u_c (
    .CLK(CLK), .RSTn(RSTn), .tohost_we(c_we), .tohost(c_tohost),
    .tohost_ready(c_ready), .fromhost_we(c_fwe), .fromhost(c_fh),
    .con_valid(c_cv), .con_data(c_cd), .con_ready(c_cr), .done(c_done),
    .pass(c_pass), .timeout(c_tmo), .exit_code(c_ec), .exit_ch(c_ech)
  );

  function automatic logic [31:0] putc(input logic [7:0] ch);
    return {8'h01, 8'h01, 8'h00, ch};
  endfunction

  task automatic clear_inputs();
    a_we = 0; a_tohost = '0; a_cr = 0;
    b_we = '0; b_tohost = '0; b_cr = 0;
    c_we = 0; c_tohost = '0; c_cr = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    clear_inputs();
    #2;
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    clear_inputs();
    #2;
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    n_chk++; if (b_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready_b: got %b want 11", b_ready); end
    n_chk++; if (a_fwe !== 1'b0) begin n_fail++; $display("FAIL reset_fwe: got %b want 0", a_fwe); end
    n_chk++; if (a_cv !== 1'b0 || a_cd !== 8'h00) begin n_fail++; $display("FAIL reset_con: got %b/%h want 0/00", a_cv, a_cd); end
    n_chk++; if ({a_done, a_pass, a_tmo} !== 3'b000) begin n_fail++; $display("FAIL reset_verdict: got %b want 000", {a_done, a_pass, a_tmo}); end
    n_chk++; if (a_ec !== 32'h0 || a_ech !== 1'b0) begin n_fail++; $display("FAIL reset_exit: got %h/%b want 0/0", a_ec, a_ech); end
    n_chk++; if (c_done !== 1'b0 || c_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_c: got %b%b want 00", c_done, c_tmo); end
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_exit_pass();
    do_reset();
    a_we = 1; a_tohost = 32'h1;
    #1;
    n_chk++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL pass_early_done: got %b want 0", a_done); end
    @(negedge CLK);
    a_we = 0;
    n_chk++; if (a_done !== 1'b1 || a_pass !== 1'b1) begin n_fail++; $display("FAIL pass_verdict: got done=%b pass=%b want 1/1", a_done, a_pass); end
    n_chk++; if (a_ec !== 32'h0 || a_tmo !== 1'b0) begin n_fail++; $display("FAIL pass_code: got %h tmo=%b want 0/0", a_ec, a_tmo); end
    n_chk++; if (a_fwe !== 1'b0) begin n_fail++; $display("FAIL pass_noack: got %b want 0", a_fwe); end
  endtask

  task automatic test_exit_code();
    do_reset();
    a_we = 1; a_tohost = 32'h0000_0007;
    @(negedge CLK);
    n_chk++; if (a_done !== 1'b1 || a_pass !== 1'b0) begin n_fail++; $display("FAIL fail_verdict: got done=%b pass=%b want 1/0", a_done, a_pass); end
    n_chk++; if (a_ec !== 32'h7 || a_ech !== 1'b0) begin n_fail++; $display("FAIL fail_code: got %h ch=%b want 7/0", a_ec, a_ech); end
    a_tohost = putc(8'h51);
    #1;
    n_chk++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL exited_ready: got %b want 1", a_ready); end
    @(negedge CLK);
    a_we = 0;
    n_chk++; if (a_fwe !== 1'b0 || a_cv !== 1'b0) begin n_fail++; $display("FAIL exited_ignore: got fwe=%b cv=%b want 0/0", a_fwe, a_cv); end
  endtask

  task automatic test_ack_putc();
    do_reset();
    a_we = 1; a_tohost = 32'h0000_0010;
    @(negedge CLK);
    a_tohost = putc(8'h48);
    n_chk++; if (a_fwe !== 1'b1 || a_fh !== 32'h1) begin n_fail++; $display("FAIL ignored_ack: got %b/%h want 1/00000001", a_fwe, a_fh); end
    n_chk++; if (a_cv !== 1'b0) begin n_fail++; $display("FAIL ignored_nocon: got %b want 0", a_cv); end
    @(negedge CLK);
    a_we = 0;
    n_chk++; if (a_cv !== 1'b1 || a_cd !== 8'h48) begin n_fail++; $display("FAIL putc_latency: got %b/%h want 1/48", a_cv, a_cd); end
    n_chk++; if (a_fwe !== 1'b1) begin n_fail++; $display("FAIL putc_ack: got %b want 1", a_fwe); end
    a_cr = 1;
    @(negedge CLK);
    a_cr = 0;
    n_chk++; if (a_cv !== 1'b0 || a_fwe !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL putc_drain: got cv=%b fwe=%b done=%b want 000", a_cv, a_fwe, a_done); end
  endtask

  task automatic test_arbitration();
    do_reset();
    b_we = 2'b11; b_tohost = {putc(8'h42), putc(8'h41)};
    #1;
    n_chk++; if (b_ready !== 2'b01) begin n_fail++; $display("FAIL arb_ready: got %b want 01", b_ready); end
    @(negedge CLK);
    n_chk++; if (b_fwe !== 2'b01) begin n_fail++; $display("FAIL arb_ack0: got %b want 01", b_fwe); end
    n_chk++; if (b_cv !== 1'b1 || b_cd !== 8'h41) begin n_fail++; $display("FAIL arb_first: got %b/%h want 1/41", b_cv, b_cd); end
    b_we = 2'b10;
    #1;
    n_chk++; if (b_ready !== 2'b11) begin n_fail++; $display("FAIL arb_ready2: got %b want 11", b_ready); end
    @(negedge CLK);
    b_we = 2'b00;
    n_chk++; if (b_fwe !== 2'b10) begin n_fail++; $display("FAIL arb_ack1: got %b want 10", b_fwe); end
    b_cr = 1;
    @(negedge CLK);
    n_chk++; if (b_cd !== 8'h42) begin n_fail++; $display("FAIL arb_second: got %h want 42", b_cd); end
    @(negedge CLK);
    b_cr = 0;
    n_chk++; if (b_cv !== 1'b0) begin n_fail++; $display("FAIL arb_empty: got %b want 0", b_cv); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b_we = 2'b01; b_tohost = {32'h0, putc(8'h41 + 8'(i))};
      #1;
      n_chk++; if (b_ready[0] !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: got %b want 1", i, b_ready[0]); end
      @(negedge CLK);
    end
    b_tohost = {32'h0, putc(8'h45)};
    #1;
    n_chk++; if (b_ready !== 2'b10) begin n_fail++; $display("FAIL full_block: got %b want 10", b_ready); end
    n_chk++; if (b_cd !== 8'h41) begin n_fail++; $display("FAIL full_head: got %h want 41", b_cd); end
    b_cr = 1;
    @(negedge CLK);
    n_chk++; if (b_ready[0] !== 1'b1 || b_fwe !== 2'b00) begin n_fail++; $display("FAIL full_after_pop: got rdy=%b fwe=%b want 1/00", b_ready[0], b_fwe); end
    n_chk++; if (b_cd !== 8'h42) begin n_fail++; $display("FAIL full_pop1: got %h want 42", b_cd); end
    @(negedge CLK);
    b_we = 2'b00;
    n_chk++; if (b_fwe !== 2'b01 || b_cd !== 8'h43) begin n_fail++; $display("FAIL full_fifth: got fwe=%b cd=%h want 01/43", b_fwe, b_cd); end
    @(negedge CLK);
    n_chk++; if (b_cd !== 8'h44) begin n_fail++; $display("FAIL full_pop3: got %h want 44", b_cd); end
    @(negedge CLK);
    n_chk++; if (b_cd !== 8'h45) begin n_fail++; $display("FAIL full_pop4: got %h want 45", b_cd); end
    @(negedge CLK);
    b_cr = 0;
    n_chk++; if (b_cv !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", b_cv); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (99) @(negedge CLK);
    n_chk++; if (c_done !== 1'b0 || c_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b%b want 00", c_done, c_tmo); end
    @(negedge CLK);
    n_chk++; if (c_done !== 1'b1 || c_tmo !== 1'b1 || c_pass !== 1'b0) begin n_fail++; $display("FAIL tmo_fire: got d=%b t=%b p=%b want 1/1/0", c_done, c_tmo, c_pass); end
    c_we = 1; c_tohost = 32'h0000_0007;
    @(negedge CLK);
    c_we = 0;
    n_chk++; if (c_ec !== 32'h0 || c_tmo !== 1'b1 || c_pass !== 1'b0) begin n_fail++; $display("FAIL tmo_late_exit: got ec=%h t=%b p=%b want 0/1/0", c_ec, c_tmo, c_pass); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_we = 1; a_tohost = putc(8'h78 + 8'(i));
      @(negedge CLK);
    end
    a_tohost = putc(8'h77); a_cr = 1;
    @(negedge CLK);
    n_chk++; if (a_cv !== 1'b1 || a_cd !== 8'h79 || a_fwe !== 1'b1) begin n_fail++; $display("FAIL drain_state: got cv=%b cd=%h fwe=%b want 1/79/1", a_cv, a_cd, a_fwe); end
    #1 RSTn = 1'b0;
    #1;
    n_chk++; if (a_cv !== 1'b0 || a_cd !== 8'h00 || a_fwe !== 1'b0) begin n_fail++; $display("FAIL drain_flush: got cv=%b cd=%h fwe=%b want 0/00/0", a_cv, a_cd, a_fwe); end
    n_chk++; if (a_done !== 1'b0 || a_ready !== 1'b1) begin n_fail++; $display("FAIL drain_fsm: got done=%b rdy=%b want 0/1", a_done, a_ready); end
    a_we = 0; a_cr = 0;
    @(negedge CLK);
    RSTn = 1'b1;
    a_we = 1; a_tohost = 32'h1;
    @(negedge CLK);
    a_we = 0;
    n_chk++; if (a_done !== 1'b1 || a_pass !== 1'b1 || a_cv !== 1'b0) begin n_fail++; $display("FAIL drain_rerun: got d=%b p=%b cv=%b want 1/1/0", a_done, a_pass, a_cv); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_exit_pass();
    test_exit_code();
    test_ack_putc();
    test_arbitration();
    test_fifo_full();
    test_timeout();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
